// File: rtl/prog_lut_if.sv
// Request/response bundle for the programmable lookup table: read and write
// requests from the master, registered read data and status from the table.
interface prog_lut_if #(
  parameter int ENTRIES = 16,
  parameter int OUT_W   = 10,
  parameter int IDX_W   = $clog2(ENTRIES)
);
  logic             rd_en;
  logic [IDX_W-1:0] index;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [OUT_W-1:0] wr_data;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             wr_ack;
  logic             ready;

  modport master (
    output rd_en, index, wr_en, wr_idx, wr_data,
    input  out, out_valid, wr_ack, ready
  );

  modport slave (
    input  rd_en, index, wr_en, wr_idx, wr_data,
    output out, out_valid, wr_ack, ready
  );
endinterface

// File: rtl/prog_lut.sv
// Programmable lookup table (PC targets / address offsets) that self-loads power-of-four
// defaults after reset. Define PROG_LUT_BYPASS_EN to forward same-index write data to a read.
module prog_lut #(
  parameter int ENTRIES = 16,
  parameter int OUT_W   = 10
) (
  input  logic     clk,
  input  logic     reset,
  prog_lut_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] cnt_r;
  logic [OUT_W-1:0] out_r;
  logic             out_valid_r;
  logic             wr_ack_r;
  logic             ready_r;
  logic [OUT_W-1:0] table_r [ENTRIES];

  logic             tbl_we_s;
  logic [IDX_W-1:0] tbl_waddr_s;
  logic [OUT_W-1:0] tbl_wdata_s;
  logic [OUT_W-1:0] rd_data_s;

  // Lower half holds -(4^(ENTRIES/2 - i)), upper half 4^(i - ENTRIES/2 + 1);
  // shifting within OUT_W bits gives the required truncation for free.
  function automatic logic [OUT_W-1:0] default_entry(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] one_v;
    int               idx_v;
    one_v = {{(OUT_W-1){1'b0}}, 1'b1};
    idx_v = int'(idx);
    if (idx_v < ENTRIES / 2) begin
      return {OUT_W{1'b0}} - (one_v << (2 * (ENTRIES / 2 - idx_v)));
    end else begin
      return one_v << (2 * (idx_v - ENTRIES / 2 + 1));
    end
  endfunction

  // Table write port: defaults during INIT, user writes in RUN, nothing under reset.
  always_comb begin
    tbl_we_s    = 1'b0;
    tbl_waddr_s = {IDX_W{1'b0}};
    tbl_wdata_s = {OUT_W{1'b0}};
    if (reset) begin
      tbl_we_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      tbl_we_s    = 1'b1;
      tbl_waddr_s = cnt_r;
      tbl_wdata_s = default_entry(cnt_r);
    end else begin
      tbl_we_s    = bus.wr_en;
      tbl_waddr_s = bus.wr_idx;
      tbl_wdata_s = bus.wr_data;
    end
  end

  // Read data source, optionally forwarding a same-cycle write to the same index.
  always_comb begin
    rd_data_s = table_r[bus.index];
`ifdef PROG_LUT_BYPASS_EN
    if (bus.wr_en && (bus.wr_idx == bus.index)) begin
      rd_data_s = bus.wr_data;
    end else begin
      rd_data_s = table_r[bus.index];
    end
`endif
  end

  // Table storage; left out of reset since INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      table_r[tbl_waddr_s] <= tbl_wdata_s;
    end
  end

  // Control FSM with registered read data and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      cnt_r       <= {IDX_W{1'b0}};
      out_r       <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      wr_ack_r    <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          out_valid_r <= 1'b0;
          wr_ack_r    <= 1'b0;
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_RUN;
            cnt_r   <= {IDX_W{1'b0}};
            ready_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + IDX_W'(1);
            ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          ready_r     <= 1'b1;
          out_valid_r <= bus.rd_en;
          wr_ack_r    <= bus.wr_en;
          if (bus.rd_en) begin
            out_r <= rd_data_s;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          cnt_r       <= {IDX_W{1'b0}};
          out_valid_r <= 1'b0;
          wr_ack_r    <= 1'b0;
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.wr_ack    = wr_ack_r;
  assign bus.ready     = ready_r;
endmodule

// File: doc/prog_lut.md
PROG_LUT -- requirements
Module: prog_lut

Interface
REQ-001 Parameter ENTRIES, default 16, table depth; power of two, at least 4.
REQ-002 Parameter OUT_W, default 10, entry width in bits, two's complement.
REQ-003 Derived IDX_W = log2(ENTRIES); default 4.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 RdEn  input  1  read request, sampled on the Clk edge.
REQ-007 Index  input  IDX_W  read address.
REQ-008 WrEn  input  1  write request.
REQ-009 WrIdx  input  IDX_W  write address.
REQ-010 WrData  input  OUT_W  write data.
REQ-011 Out  output  OUT_W  registered read data (PC target / address offset).
REQ-012 OutValid  output  1  high the cycle after an accepted read.
REQ-013 WrAck  output  1  high the cycle after an accepted write.
REQ-014 Ready  output  1  high when table initialisation is complete.

Function
REQ-015 FSM states: INIT and RUN; Reset forces INIT with init counter 0.
REQ-016 In INIT, each cycle writes the default value of entry counter, then increments; the counter reaching ENTRIES-1 moves the FSM to RUN next cycle, so INIT lasts exactly ENTRIES cycles.
REQ-017 Default entry i for i < ENTRIES/2: -(4^(ENTRIES/2 - i)); for i >= ENTRIES/2: 4^(i - ENTRIES/2 + 1); both truncated to OUT_W bits.
REQ-018 For defaults (16, 10): entry 7 = -4, 6 = -16, 5 = -64, 4 = -256, 8 = 4, 9 = 16, 10 = 64, 11 = 256.
REQ-019 Ready = 1 only in RUN.
REQ-020 In INIT, RdEn and WrEn are ignored: no table change, OutValid = 0, WrAck = 0.
REQ-021 In RUN, RdEn = 1 loads Out with entry[Index] at the edge; OutValid = 1 for that next cycle only; read latency is one cycle.
REQ-022 With RdEn = 0, Out holds its last value and OutValid = 0.
REQ-023 In RUN, WrEn = 1 stores WrData into entry[WrIdx] at the edge; WrAck = 1 for the next cycle only.
REQ-024 Read and write in the same cycle to different indices both complete.
REQ-025 Read and write in the same cycle to the same index: Out behaviour per REQ-031/REQ-032; the table always holds WrData afterwards.
REQ-026 Back-to-back reads and writes every cycle are accepted with no stall.

Reset
REQ-027 Reset forces Out = 0, OutValid = 0, WrAck = 0, Ready = 0, state INIT, counter 0.
REQ-028 Reset asserted mid-INIT or mid-RUN restarts initialisation from entry 0; user writes made before the reset are overwritten with defaults.
REQ-029 Reset has priority over RdEn and WrEn in the same cycle.

Configuration
REQ-030 Macro PROG_LUT_BYPASS_EN selects same-index read/write forwarding.
REQ-031 With PROG_LUT_BYPASS_EN defined, a same-cycle same-index read returns WrData on Out.
REQ-032 Without PROG_LUT_BYPASS_EN, a same-cycle same-index read returns the pre-write entry value.

Verification
REQ-033 Reset for 1 cycle, then release -> Ready = 0 for exactly 16 cycles, then 1; Out = 0 throughout.
REQ-034 After Ready, RdEn with Index = 7, then 9, then 4 -> Out = -4 (0x3FC), 16, -256 (0x300) on consecutive cycles; OutValid = 1 each cycle.
REQ-035 WrEn, WrIdx = 3, WrData = 26 -> WrAck = 1 next cycle; a later read of Index 3 returns 26.
REQ-036 Same cycle WrEn, WrIdx = 8, WrData = 104 and RdEn, Index = 8 -> Out = 104 with the macro, Out = 4 without; a following read returns 104 in both builds.
REQ-037 Write 26 to index 3, assert Reset at cycle 5 of a new INIT -> 16 INIT cycles from release; index 3 reads its default value.
REQ-038 RdEn and WrEn held during INIT -> OutValid and WrAck stay 0; table holds defaults.
